// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary in, packed BCD digits out
// (4'hF = blank digit for the downstream 7-segment decoders).
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_to_bcd_seq_if.slave bus
);

    // Number of decimal digits needed for 2^w-1.
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int unsigned SD = dec_digits(WIDTH);          // scratch digits
    localparam int unsigned ND = (SD > DIGITS) ? SD : DIGITS; // formatting span
    localparam int unsigned SW = 4 * SD;
    localparam int unsigned EW = 4 * ND;
    localparam int unsigned OW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, sreg_step;
    logic [SW-1:0]   scr_q, scr_d, scr_adj, scr_step;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [EW-1:0]   ext;
    logic [OW-1:0]   fmt;
    logic            ovf_calc;
    logic            lead;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: one add-3/shift step per cycle; the last step's value
    // is formatted (overflow, leading-zero blanking) and written to the output.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        scr_adj = scr_q;
        for (int unsigned i = 0; i < SD; i++) begin
            if (scr_adj[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_adj[4*i +: 4] + 4'd3;
            end
        end
        {scr_step, sreg_step} = {scr_adj, sreg_q} << 1;

        ext      = EW'(scr_step);
        ovf_calc = 1'b0;
        for (int unsigned i = DIGITS; i < ND; i++) begin
            ovf_calc = ovf_calc | (|ext[4*i +: 4]);
        end

        // Blank zeros from the top down until the first nonzero digit; digit 0 always shows.
        fmt  = ext[OW-1:0];
        lead = BLANK_LZ;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            if (lead && (fmt[4*(DIGITS-1-k) +: 4] == 4'd0)) begin
                fmt[4*(DIGITS-1-k) +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        if (ovf_calc) begin
            fmt = '1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d  = bus.bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d  = scr_step;
                sreg_d = sreg_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = fmt;
                    ovf_d   = ovf_calc;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule
